// File: rtl/regfile_bypass_sb.sv
// Integer register file with NREAD synchronous read ports, one write port with
// same-edge write-to-read bypass, and a per-register pending-write scoreboard.
module regfile_bypass_sb #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int CNTW  = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr,
  input  logic                  rd_hold,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  input  logic                  flush,
  output logic                  sb_overflow
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]       regs     [NREGS];
  logic [CNTW-1:0]       cnt      [NREGS];
  logic [CNTW-1:0]       cnt_next [NREGS];
  logic [AW-1:0]         addr_p   [NREAD];
  logic [NREAD*XLEN-1:0] rd_data_d;
  logic [NREAD-1:0]      rd_busy_d;
  logic                  wr_ok;
  logic                  rsv_ok;
  logic                  ovf_set;

  // Register 0 is hardwired: neither writes nor reserves may touch it.
  assign wr_ok  = wr_en  && (wr_addr  != '0);
  assign rsv_ok = rsv_en && (rsv_addr != '0);

  // A reserve and a write to the same register cancel out; flush wins over both.
  always_comb begin
    ovf_set = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_next[r] = cnt[r];
      if (flush) begin
        cnt_next[r] = '0;
      end else if (rsv_ok && (rsv_addr == AW'(r)) &&
                   !(wr_ok && (wr_addr == AW'(r)))) begin
        if (cnt[r] == CNT_MAX) ovf_set = 1'b1;
        else                   cnt_next[r] = cnt[r] + CNTW'(1);
      end else if (wr_ok && (wr_addr == AW'(r)) &&
                   !(rsv_ok && (rsv_addr == AW'(r)))) begin
        if (cnt[r] != '0) cnt_next[r] = cnt[r] - CNTW'(1);
      end
    end
  end

  // Busy looks at cnt_next so a reserve on this edge is already visible.
  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int p = 0; p < NREAD; p++) begin
      addr_p[p] = rd_addr[p*AW +: AW];
      if (addr_p[p] != '0) begin
        if (wr_en && (wr_addr == addr_p[p])) rd_data_d[p*XLEN +: XLEN] = wr_data;
        else                                 rd_data_d[p*XLEN +: XLEN] = regs[addr_p[p]];
        rd_busy_d[p] = (cnt_next[addr_p[p]] != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      rd_data     <= '0;
      rd_busy     <= '0;
      sb_overflow <= 1'b0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_next[r];
      if (ovf_set) sb_overflow <= 1'b1;
      if (!rd_hold) begin
        rd_data <= rd_data_d;
        rd_busy <= rd_busy_d;
      end
    end
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: default configuration against a behavioural
// model, plus a 32-bit/16-register/4-port instance checked with directed values.
module tb_regfile_bypass_sb;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // instance A: XLEN=64, NREGS=32, NREAD=2, CNTW=2
  logic         rst_a, rd_hold_a, wr_en_a, rsv_en_a, flush_a, ovf_a;
  logic [9:0]   rd_addr_a;
  logic [127:0] rd_data_a;
  logic [1:0]   rd_busy_a;
  logic [4:0]   wr_addr_a, rsv_addr_a;
  logic [63:0]  wr_data_a;

  regfile_bypass_sb dut_a (
    .clk(clk), .rst(rst_a), .rd_addr(rd_addr_a), .rd_hold(rd_hold_a),
    .rd_data(rd_data_a), .rd_busy(rd_busy_a), .wr_en(wr_en_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .rsv_en(rsv_en_a),
    .rsv_addr(rsv_addr_a), .flush(flush_a), .sb_overflow(ovf_a)
  );

  // instance B: XLEN=32, NREGS=16, NREAD=4
  logic         rst_b, rd_hold_b, wr_en_b, rsv_en_b, flush_b, ovf_b;
  logic [15:0]  rd_addr_b;
  logic [127:0] rd_data_b;
  logic [3:0]   rd_busy_b;
  logic [3:0]   wr_addr_b, rsv_addr_b;
  logic [31:0]  wr_data_b;

  regfile_bypass_sb #(.XLEN(32), .NREGS(16), .NREAD(4), .CNTW(2)) dut_b (
    .clk(clk), .rst(rst_b), .rd_addr(rd_addr_b), .rd_hold(rd_hold_b),
    .rd_data(rd_data_b), .rd_busy(rd_busy_b), .wr_en(wr_en_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .rsv_en(rsv_en_b),
    .rsv_addr(rsv_addr_b), .flush(flush_b), .sb_overflow(ovf_b)
  );

  // reference model for instance A
  logic [63:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_ovf;
  logic [63:0] m_data [2];
  logic [1:0]  m_busy;

  task automatic tick_a();
    int          nc [32];
    logic [63:0] nd [2];
    logic [1:0]  nb;
    bit          w_ok, r_ok, ovf_n;
    int          a;
    w_ok  = wr_en_a  && (wr_addr_a  != 0);
    r_ok  = rsv_en_a && (rsv_addr_a != 0);
    ovf_n = 0;
    nc = m_cnt;
    if (flush_a) begin
      foreach (nc[i]) nc[i] = 0;
    end else if (!(w_ok && r_ok && wr_addr_a == rsv_addr_a)) begin
      if (r_ok) begin
        if (nc[rsv_addr_a] == 3) ovf_n = 1;
        else nc[rsv_addr_a] = nc[rsv_addr_a] + 1;
      end
      if (w_ok && nc[wr_addr_a] > 0) nc[wr_addr_a] = nc[wr_addr_a] - 1;
    end
    for (int p = 0; p < 2; p++) begin
      a = int'(rd_addr_a[p*5 +: 5]);
      if (a == 0) begin
        nd[p] = '0;
        nb[p] = 1'b0;
      end else begin
        nd[p] = (wr_en_a && wr_addr_a == 5'(a)) ? wr_data_a : m_regs[a];
        nb[p] = (nc[a] != 0);
      end
    end
    @(posedge clk);
    #1;
    if (rst_a) begin
      foreach (m_regs[i]) begin
        m_regs[i] = '0;
        m_cnt[i]  = 0;
      end
      m_data[0] = '0;
      m_data[1] = '0;
      m_busy    = '0;
      m_ovf     = 0;
    end else begin
      if (w_ok) m_regs[wr_addr_a] = wr_data_a;
      m_cnt = nc;
      m_ovf = m_ovf | ovf_n;
      if (!rd_hold_a) begin
        m_data[0] = nd[0];
        m_data[1] = nd[1];
        m_busy    = nb;
      end
    end
  endtask

  // driver tasks
  task automatic idle_a();
    rst_a = 0; rd_hold_a = 0; wr_en_a = 0; rsv_en_a = 0; flush_a = 0;
  endtask

  task automatic set_rd_a(input int a0, input int a1);
    rd_addr_a = {5'(a1), 5'(a0)};
  endtask

  task automatic write_a(input int a, input logic [63:0] d);
    wr_en_a = 1; wr_addr_a = 5'(a); wr_data_a = d;
  endtask

  task automatic test_reset();
    rst_a = 1; rd_hold_a = 1; wr_en_a = 1; wr_addr_a = 5'd5; wr_data_a = 64'hBAD;
    rsv_en_a = 1; rsv_addr_a = 5'd5; flush_a = 0; set_rd_a(5, 5);
    tick_a();
    checks++;
    if (rd_data_a !== '0 || rd_busy_a !== 2'b00 || ovf_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: data=%h busy=%b ovf=%b required all zero", rd_data_a, rd_busy_a, ovf_a);
    end
    idle_a(); set_rd_a(5, 0);
    tick_a();
    checks++;
    if (rd_data_a !== '0 || rd_busy_a !== 2'b00) begin
      failures++;
      $display("FAIL reset_read: data=%h busy=%b required 0/00", rd_data_a, rd_busy_a);
    end
    write_a(5, 64'h1234);
    tick_a();
    idle_a(); set_rd_a(5, 0);
    tick_a();
    checks++;
    if (rd_data_a[63:0] !== 64'h1234) begin
      failures++;
      $display("FAIL read_after_write: got %h required 1234", rd_data_a[63:0]);
    end
  endtask

  task automatic test_bypass();
    write_a(7, 64'hDEAD_BEEF); set_rd_a(7, 7);
    tick_a();
    checks++;
    if (rd_data_a !== {64'hDEAD_BEEF, 64'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL bypass_both_ports: got %h required deadbeef on both", rd_data_a);
    end
    write_a(0, 64'hFF); set_rd_a(0, 0);
    tick_a();
    checks++;
    if (rd_data_a !== '0) begin
      failures++;
      $display("FAIL x0_bypass: got %h required 0", rd_data_a);
    end
    idle_a();
    tick_a();
    checks++;
    if (rd_data_a !== '0) begin
      failures++;
      $display("FAIL x0_read: got %h required 0", rd_data_a);
    end
  endtask

  task automatic test_scoreboard();
    idle_a(); set_rd_a(3, 0);
    rsv_en_a = 1; rsv_addr_a = 5'd3;
    tick_a();
    tick_a();
    checks++;
    if (rd_busy_a !== 2'b01) begin
      failures++;
      $display("FAIL sb_two_rsv: busy=%b required 01", rd_busy_a);
    end
    rsv_en_a = 0; write_a(3, 64'h33);
    tick_a();
    checks++;
    if (rd_busy_a !== 2'b01) begin
      failures++;
      $display("FAIL sb_one_write: busy=%b required 01", rd_busy_a);
    end
    rsv_en_a = 1; rsv_addr_a = 5'd3; write_a(3, 64'h34);
    tick_a();
    checks++;
    if (rd_busy_a !== 2'b01 || rd_data_a[63:0] !== 64'h34) begin
      failures++;
      $display("FAIL sb_rsv_and_write: busy=%b data=%h required 01/34", rd_busy_a, rd_data_a[63:0]);
    end
    rsv_en_a = 0; write_a(3, 64'h35);
    tick_a();
    checks++;
    if (rd_busy_a !== 2'b00) begin
      failures++;
      $display("FAIL sb_release: busy=%b required 00", rd_busy_a);
    end
    idle_a();
  endtask

  task automatic test_saturation();
    idle_a(); set_rd_a(9, 9);
    rsv_en_a = 1; rsv_addr_a = 5'd9;
    for (int i = 0; i < 3; i++) tick_a();
    checks++;
    if (ovf_a !== 1'b0 || rd_busy_a !== 2'b11) begin
      failures++;
      $display("FAIL sat_three_rsv: ovf=%b busy=%b required 0/11", ovf_a, rd_busy_a);
    end
    tick_a();
    rsv_en_a = 0;
    tick_a();
    tick_a();
    checks++;
    if (ovf_a !== 1'b1) begin
      failures++;
      $display("FAIL sat_overflow_sticky: ovf=%b required 1", ovf_a);
    end
    for (int i = 0; i < 2; i++) begin
      write_a(9, 64'h90 + 64'(i));
      tick_a();
    end
    checks++;
    if (rd_busy_a !== 2'b11) begin
      failures++;
      $display("FAIL sat_two_writes: busy=%b required 11", rd_busy_a);
    end
    write_a(9, 64'h92);
    tick_a();
    checks++;
    if (rd_busy_a !== 2'b00) begin
      failures++;
      $display("FAIL sat_three_writes: busy=%b required 00", rd_busy_a);
    end
    write_a(9, 64'hABC);
    tick_a();
    idle_a();
    tick_a();
    checks++;
    if (rd_data_a[63:0] !== 64'hABC || rd_busy_a !== 2'b00) begin
      failures++;
      $display("FAIL underflow_write: data=%h busy=%b required abc/00", rd_data_a[63:0], rd_busy_a);
    end
    rsv_en_a = 1; rsv_addr_a = 5'd9;
    tick_a();
    rsv_en_a = 0; write_a(9, 64'hABD);
    tick_a();
    checks++;
    if (rd_busy_a !== 2'b00) begin
      failures++;
      $display("FAIL no_underflow_wrap: busy=%b required 00", rd_busy_a);
    end
    idle_a();
  endtask

  task automatic test_hold_flush();
    idle_a(); write_a(4, 64'h11); set_rd_a(4, 4);
    tick_a();
    rd_hold_a = 1; write_a(4, 64'h55);
    tick_a();
    checks++;
    if (rd_data_a[63:0] !== 64'h11) begin
      failures++;
      $display("FAIL hold_frozen: got %h required 11", rd_data_a[63:0]);
    end
    idle_a();
    tick_a();
    checks++;
    if (rd_data_a[63:0] !== 64'h55) begin
      failures++;
      $display("FAIL hold_release: got %h required 55", rd_data_a[63:0]);
    end
    write_a(2, 64'h22);
    tick_a();
    idle_a(); set_rd_a(2, 6);
    rsv_en_a = 1; rsv_addr_a = 5'd2;
    tick_a();
    rsv_addr_a = 5'd6;
    tick_a();
    checks++;
    if (rd_busy_a !== 2'b11) begin
      failures++;
      $display("FAIL pre_flush_busy: busy=%b required 11", rd_busy_a);
    end
    rsv_en_a = 0; flush_a = 1;
    tick_a();
    checks++;
    if (rd_busy_a !== 2'b00 || rd_data_a !== {64'h0, 64'h22}) begin
      failures++;
      $display("FAIL flush: busy=%b data=%h required 00/22 and 0", rd_busy_a, rd_data_a);
    end
    idle_a();
  endtask

  task automatic test_reset_midstate();
    rsv_en_a = 1; rsv_addr_a = 5'd3; rd_hold_a = 1; set_rd_a(3, 9);
    tick_a();
    rst_a = 1; wr_en_a = 1; wr_addr_a = 5'd3; wr_data_a = 64'h77;
    tick_a();
    checks++;
    if (rd_data_a !== '0 || rd_busy_a !== 2'b00 || ovf_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_midstate: data=%h busy=%b ovf=%b required all zero", rd_data_a, rd_busy_a, ovf_a);
    end
    idle_a();
    tick_a();
    checks++;
    if (rd_data_a !== '0 || rd_busy_a !== 2'b00) begin
      failures++;
      $display("FAIL reset_cleared_regs: data=%h busy=%b required all zero", rd_data_a, rd_busy_a);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_a      = ($urandom_range(0, 99) == 0);
      rd_hold_a  = ($urandom_range(0, 4) == 0);
      flush_a    = ($urandom_range(0, 24) == 0);
      wr_en_a    = $urandom_range(0, 1);
      rsv_en_a   = $urandom_range(0, 1);
      wr_addr_a  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rsv_addr_a = 5'($urandom_range(0, 7));
      wr_data_a  = {$urandom, $urandom};
      set_rd_a($urandom_range(0, 7), $urandom_range(0, 7));
      tick_a();
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rd_data_a[p*64 +: 64] !== m_data[p]) begin
          failures++;
          $display("FAIL rand_data[%0d] cyc %0d: got %h required %h", p, n, rd_data_a[p*64 +: 64], m_data[p]);
        end
      end
      checks++;
      if (rd_busy_a !== m_busy || ovf_a !== m_ovf) begin
        failures++;
        $display("FAIL rand_busy_ovf cyc %0d: got %b/%b required %b/%b", n, rd_busy_a, ovf_a, m_busy, m_ovf);
      end
    end
    idle_a();
  endtask

  task automatic test_param_sweep();
    logic [127:0] exp_d;
    rst_b = 1;
    @(posedge clk); #1;
    rst_b = 0; rd_hold_b = 0; flush_b = 0; rsv_en_b = 0; wr_en_b = 1;
    for (int r = 1; r <= 3; r++) begin
      wr_addr_b = 4'(r);
      wr_data_b = 32'h1111_1111 * 32'(r);
      @(posedge clk); #1;
    end
    wr_addr_b = 4'd5; wr_data_b = 32'h5555_5555;
    rsv_en_b = 1; rsv_addr_b = 4'd3;
    rd_addr_b = {4'd5, 4'd3, 4'd2, 4'd1};
    @(posedge clk); #1;
    exp_d = {32'h5555_5555, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rd_data_b[p*32 +: 32] !== exp_d[p*32 +: 32]) begin
        failures++;
        $display("FAIL sweep_port%0d: got %h required %h", p, rd_data_b[p*32 +: 32], exp_d[p*32 +: 32]);
      end
    end
    checks++;
    if (rd_busy_b !== 4'b0100) begin
      failures++;
      $display("FAIL sweep_busy: got %b required 0100", rd_busy_b);
    end
    wr_en_b = 0; rsv_en_b = 0;
    rd_addr_b = {4'd0, 4'd5, 4'd5, 4'd0};
    @(posedge clk); #1;
    checks++;
    if (rd_data_b !== {32'h0, 32'h5555_5555, 32'h5555_5555, 32'h0}) begin
      failures++;
      $display("FAIL sweep_dup_ports: got %h required 0/55555555/55555555/0", rd_data_b);
    end
  endtask

  initial begin
    rst_a = 1; rd_hold_a = 0; wr_en_a = 0; rsv_en_a = 0; flush_a = 0;
    rd_addr_a = '0; wr_addr_a = '0; wr_data_a = '0; rsv_addr_a = '0;
    rst_b = 1; rd_hold_b = 0; wr_en_b = 0; rsv_en_b = 0; flush_b = 0;
    rd_addr_b = '0; wr_addr_b = '0; wr_data_b = '0; rsv_addr_b = '0;
    foreach (m_regs[i]) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
    m_data[0] = '0; m_data[1] = '0; m_busy = '0; m_ovf = 0;
    #2;
    test_reset();
    test_bypass();
    test_scoreboard();
    test_saturation();
    test_hold_flush();
    test_reset_midstate();
    test_random();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
